fifo_write_arbiter: RTL and testbench

Round-robin arbiter that shares a single FIFO write port among N requesters. It grants one requester at a time for a burst of up to MAX_BURST words and muxes that requester's data onto the FIFO write port. Writes stall while the FIFO reports full. It sits in the write-clock domain directly in front of the async FIFO's wEn/wData/full port.

---
 rtl/fifo_write_arbiter_if.sv | 24 ++
 rtl/fifo_write_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_write_arbiter.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_if.sv
// rtl/fifo_write_arbiter_if.sv - requester lanes and FIFO write port shared by the round-robin arbiter
interface fifo_write_arbiter_if #(
  parameter int N = 4,
  parameter int W = 32
);
  logic [N-1:0]   req;
  logic [N*W-1:0] reqData;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           busy;
  logic           wEn;
  logic [W-1:0]   wData;
  logic           full;

  modport master (
    input  req, reqData, full,
    output ack, grant, busy, wEn, wData
  );

  modport slave (
    output req, reqData, full,
    input  ack, grant, busy, wEn, wData
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter muxing N requesters onto one FIFO write port
module fifo_write_arbiter #(
  parameter int N         = 4,
  parameter int W         = 32,
  parameter int MAX_BURST = 8
) (
  input logic                i_clk,
  input logic                i_rst,
  fifo_write_arbiter_if.master bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state;
  logic [IW-1:0]   r_g;
  logic [IW-1:0]   r_last;
  logic [CW-1:0]   r_cnt;
  logic [N-1:0]    r_grant;

  logic [W-1:0]    w_lanes [N];
  logic            w_req_g;
  logic            w_xfer;
  logic            w_last_word;
  logic [IW-1:0]   w_idx;
  logic [IW-1:0]   w_pick;
  logic [N-1:0]    w_pick_oh;
  logic            w_any_req;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_lanes[i] = bus.reqData[i*W +: W];
    end
  end

  assign w_req_g     = bus.req[r_g];
  assign w_xfer      = (r_state == S_BURST) && w_req_g && !bus.full && !i_rst;
  assign w_last_word = (r_cnt == CW'(MAX_BURST - 1));
  assign w_any_req   = |bus.req;

  // Scan from farthest to nearest so the nearest requester after r_last wins.
  always_comb begin
    w_pick = r_last;
    w_idx  = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IW'((int'(r_last) + k) % N);
      if (bus.req[w_idx]) begin
        w_pick = w_idx;
      end
    end
    for (int i = 0; i < N; i++) begin
      w_pick_oh[i] = (w_pick == IW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.ack[i] = w_xfer && (r_g == IW'(i));
    end
  end

  assign bus.wEn   = w_xfer;
  assign bus.wData = w_lanes[r_g];
  assign bus.grant = r_grant;
  assign bus.busy  = (r_state == S_BURST);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_g     <= '0;
      r_last  <= IW'(N - 1);
      r_cnt   <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_g     <= w_pick;
            r_grant <= w_pick_oh;
            r_cnt   <= '0;
            r_state <= S_BURST;
          end
        end
        S_BURST: begin
          if (!w_req_g) begin
            r_state <= S_IDLE;
            r_last  <= r_g;
            r_grant <= '0;
            r_cnt   <= '0;
          end else if (!bus.full) begin
            if (w_last_word) begin
              r_state <= S_IDLE;
              r_last  <= r_g;
              r_grant <= '0;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CW'(1);
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb/tb_fifo_write_arbiter.sv - directed and randomized checks of the round-robin FIFO write arbiter
module tb_fifo_write_arbiter;
  localparam int N     = 4;
  localparam int W     = 32;
  localparam int MB    = 8;
  localparam int BOUND = (N - 1) * (MB + 1) + 1;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;
  int   seq [N];

  fifo_write_arbiter_if #(.N(N), .W(W)) bus ();

  fifo_write_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] lane(int i);
    return {4'hA, 4'(i), 24'(seq[i])};
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < N; i++) bus.reqData[i*W +: W] = lane(i);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int idx_of(logic [N-1:0] oh);
    for (int i = 0; i < N; i++) if (oh[i]) return i;
    return 0;
  endfunction

  function automatic logic [N-1:0] oh_of(int i);
    logic [N-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Inputs are set at posedge+1, outputs checked at posedge+3.
  task automatic cyc(string tag, logic [N-1:0] eg, logic ew, logic eb);
    #2;
    chk({tag, " grant"}, 32'(bus.grant), 32'(eg));
    chk({tag, " wEn"},   32'(bus.wEn),   32'(ew));
    chk({tag, " ack"},   32'(bus.ack),   ew ? 32'(eg) : 32'd0);
    chk({tag, " busy"},  32'(bus.busy),  32'(eb));
    if (ew) chk({tag, " wData"}, bus.wData, lane(idx_of(eg)));
    @(posedge clk);
    #1;
    if (ew) begin
      seq[idx_of(eg)]++;
      drive_lanes();
    end
  endtask

  task automatic burst(string tag, int owner, int nw);
    for (int k = 0; k < nw; k++) cyc(tag, oh_of(owner), 1'b1, 1'b1);
  endtask

  task automatic idle(string tag);
    cyc(tag, '0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N-1:0] prev_ack;
    int wait_c [N];
    int stall_c [N];

    for (int i = 0; i < N; i++) begin
      seq[i]     = 0;
      wait_c[i]  = 0;
      stall_c[i] = 0;
    end
    rst      = 1'b1;
    bus.req  = 4'b0010;
    bus.full = 1'b0;
    drive_lanes();

    #2;
    chk("rst0 wEn", 32'(bus.wEn), 32'd0);
    chk("rst0 ack", 32'(bus.ack), 32'd0);
    @(posedge clk);
    #1;
    cyc("rst1", '0, 1'b0, 1'b0);
    rst = 1'b0;

    idle("single arb");
    burst("single b1", 1, MB);
    idle("single gap");
    burst("single b2", 1, MB);
    bus.req = '0;
    idle("noreq a");
    idle("noreq b");

    bus.req = 4'b1111;
    idle("rr arb");
    burst("rr g2", 2, MB);
    idle("rr gap2");
    burst("rr g3", 3, MB);
    idle("rr gap3");
    burst("rr g0", 0, MB);
    idle("rr gap0");
    burst("rr g1", 1, MB);
    idle("rr gap1");

    burst("early g2", 2, 3);
    bus.req = 4'b1011;
    cyc("early drop", 4'b0100, 1'b0, 1'b1);
    idle("early gap");
    burst("early g3", 3, MB);
    idle("early wrap");

    burst("bp pre", 0, 3);
    bus.full = 1'b1;
    for (int k = 0; k < 5; k++) cyc("bp stall", 4'b0001, 1'b0, 1'b1);
    bus.full = 1'b0;
    burst("bp post", 0, MB - 3);
    idle("bp gap");

    burst("rstmid g1", 1, 4);
    rst = 1'b1;
    cyc("rstmid hit", 4'b0010, 1'b0, 1'b1);
    rst     = 1'b0;
    bus.req = 4'b1111;
    idle("rstmid after");
    burst("rstmid g0", 0, MB);
    idle("rstmid gap");
    burst("rstmid g1b", 1, 2);

    prev_ack = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (prev_ack[i]) begin
          seq[i]++;
          if ($urandom_range(0, 1) == 0) bus.req[i] = 1'b0;
        end else if (!bus.req[i] && $urandom_range(0, 3) == 0) begin
          bus.req[i] = 1'b1;
        end
      end
      drive_lanes();
      bus.full = ($urandom_range(0, 3) == 0);
      #2;
      chk("rnd ack onehot0", 32'($onehot0(bus.ack)), 32'd1);
      chk("rnd wEn vs ack", 32'(bus.wEn), 32'(|bus.ack));
      if (bus.wEn) chk("rnd wData", bus.wData, lane(idx_of(bus.ack)));
      for (int i = 0; i < N; i++) begin
        if (bus.req[i] && !bus.ack[i]) begin
          wait_c[i]++;
          if (bus.full) stall_c[i]++;
          chk("rnd starvation", 32'(wait_c[i] > BOUND + stall_c[i]), 32'd0);
        end else begin
          wait_c[i]  = 0;
          stall_c[i] = 0;
        end
      end
      prev_ack = bus.ack;
      @(posedge clk);
      #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
